ras_ckpt: RTL and testbench



---
 rtl/ras_ckpt.sv | 106 ++++++++++
 tb/tb_ras_ckpt.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// ras_ckpt: checkpoint-restorable return address stack for the fetch predictor.
// Fetch pushes on predicted calls and pops on predicted returns. A mispredict
// restores the {index, count, top target} snapshot taken with the prediction.
module ras_ckpt #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_TARGET_WIDTH = 31,
    parameter logic [RAS_TARGET_WIDTH-1:0] RAS_INIT_TARGET = '0,
    parameter int RAS_REPAIR_TOP   = 1,
    localparam int IW = $clog2(RAS_ENTRIES),
    localparam int CW = $clog2(RAS_ENTRIES + 1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    input  logic                        restore_valid,
    input  logic [IW-1:0]               restore_index,
    input  logic [CW-1:0]               restore_count,
    input  logic [RAS_TARGET_WIDTH-1:0] restore_top_target,
    output logic [RAS_TARGET_WIDTH-1:0] top_target,
    output logic [IW-1:0]               top_index,
    output logic [CW-1:0]               top_count,
    output logic                        empty
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_ENTRIES);

    logic [RAS_TARGET_WIDTH-1:0] entry [RAS_ENTRIES];
    logic [IW-1:0]               ptr;
    logic [CW-1:0]               count;

    logic [IW-1:0]               ptr_nxt;
    logic [CW-1:0]               count_nxt;
    logic                        wr_en;
    logic [IW-1:0]               wr_idx;
    logic [RAS_TARGET_WIDTH-1:0] wr_data;

    // Work out the next pointer/count and the single entry write for this cycle;
    // restore outranks push/pop, and push+pop together replaces the top in place.
    always_comb begin
        ptr_nxt   = ptr;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = ptr;
        wr_data   = push_target;
        if (restore_valid) begin
            ptr_nxt   = restore_index;
            count_nxt = restore_count;
            wr_en     = (RAS_REPAIR_TOP != 0);
            wr_idx    = restore_index;
            wr_data   = restore_top_target;
        end else if (push_valid && pop_valid) begin
            wr_en = 1'b1;
            if (count == '0) begin
                count_nxt = CW'(1);
            end
        end else if (push_valid) begin
            ptr_nxt = ptr + 1'b1;
            wr_en   = 1'b1;
            wr_idx  = ptr + 1'b1;
            if (count != FULL_COUNT) begin
                count_nxt = count + 1'b1;
            end
        end else if (pop_valid) begin
            ptr_nxt = ptr - 1'b1;
            if (count != '0) begin
                count_nxt = count - 1'b1;
            end
        end
    end

    // Pointer and count registers; underflowing pops still move the pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr   <= '0;
            count <= '0;
        end else begin
            ptr   <= ptr_nxt;
            count <= count_nxt;
        end
    end

    // Stack storage; overflow silently overwrites the oldest entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entry[i] <= RAS_INIT_TARGET;
            end
        end else if (wr_en) begin
            entry[wr_idx] <= wr_data;
        end
    end

    // Snapshot outputs come straight from registered state.
    always_comb begin
        top_target = entry[ptr];
        top_index  = ptr;
        top_count  = count;
        empty      = (count == '0);
    end

    restore_count_legal: assert property (@(posedge CLK) disable iff (RST)
        restore_valid |-> (restore_count <= FULL_COUNT));

endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed test of ras_ckpt with and without top-entry repair,
// checked every cycle against a behavioural stack model plus literal values.
module tb_ras_ckpt;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        push_valid = 1'b0;
    logic [30:0] push_target = '0;
    logic        pop_valid = 1'b0;
    logic        restore_valid = 1'b0;
    logic [2:0]  restore_index = '0;
    logic [3:0]  restore_count = '0;
    logic [30:0] restore_top_target = '0;

    logic [30:0] top_r, top_n;
    logic [2:0]  idx_r, idx_n;
    logic [3:0]  cnt_r, cnt_n;
    logic        emp_r, emp_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: index 0 repairs the top on restore, index 1 does not.
    logic [30:0] m_ent [2][8];
    int          m_ptr [2];
    int          m_cnt [2];

    ras_ckpt #(.RAS_ENTRIES(8), .RAS_TARGET_WIDTH(31), .RAS_INIT_TARGET('0), .RAS_REPAIR_TOP(1)) dut (
        .CLK(CLK), .RST(RST),
        .push_valid(push_valid), .push_target(push_target), .pop_valid(pop_valid),
        .restore_valid(restore_valid), .restore_index(restore_index),
        .restore_count(restore_count), .restore_top_target(restore_top_target),
        .top_target(top_r), .top_index(idx_r), .top_count(cnt_r), .empty(emp_r));

    ras_ckpt #(.RAS_ENTRIES(8), .RAS_TARGET_WIDTH(31), .RAS_INIT_TARGET('0), .RAS_REPAIR_TOP(0)) dut_nr (
        .CLK(CLK), .RST(RST),
        .push_valid(push_valid), .push_target(push_target), .pop_valid(pop_valid),
        .restore_valid(restore_valid), .restore_index(restore_index),
        .restore_count(restore_count), .restore_top_target(restore_top_target),
        .top_target(top_n), .top_index(idx_n), .top_count(cnt_n), .empty(emp_n));

    always #5 CLK = ~CLK;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input int idx, input int cnt,
                               input logic [30:0] top, input bit emp);
        checkVal({name, ".index"}, 32'(idx_r), 32'(idx));
        checkVal({name, ".count"}, 32'(cnt_r), 32'(cnt));
        checkVal({name, ".top"},   32'(top_r), 32'(top));
        checkVal({name, ".empty"}, 32'(emp_r), 32'(emp));
    endtask

    // One clock of stimulus; inputs change at the falling edge and return to idle.
    task automatic applyStimulus(input bit ps, input logic [30:0] pt, input bit pp,
                                 input bit rv, input logic [2:0] ri, input logic [3:0] rc,
                                 input logic [30:0] rt);
        push_valid = ps; push_target = pt; pop_valid = pp;
        restore_valid = rv; restore_index = ri; restore_count = rc; restore_top_target = rt;
        @(posedge CLK);
        @(negedge CLK);
        push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
    endtask

    task automatic doPush(input logic [30:0] v);
        applyStimulus(1'b1, v, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic doPop(input logic [30:0] expect_val);
        checkVal("pop_value", 32'(top_r), 32'(expect_val));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
    endtask

    task automatic pulseReset();
        #2 RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Stack model updated from the stack rules with plain integer arithmetic.
    always @(posedge CLK or posedge RST) begin
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                m_ptr[k] <= 0;
                m_cnt[k] <= 0;
                for (int i = 0; i < 8; i++) m_ent[k][i] <= '0;
            end else if (restore_valid) begin
                m_ptr[k] <= int'(restore_index);
                m_cnt[k] <= int'(restore_count);
                if (k == 0) m_ent[k][restore_index] <= restore_top_target;
            end else if (push_valid && pop_valid) begin
                m_ent[k][m_ptr[k]] <= push_target;
                m_cnt[k] <= (m_cnt[k] == 0) ? 1 : m_cnt[k];
            end else if (push_valid) begin
                m_ptr[k] <= (m_ptr[k] + 1) % 8;
                m_ent[k][(m_ptr[k] + 1) % 8] <= push_target;
                m_cnt[k] <= (m_cnt[k] + 1 > 8) ? 8 : m_cnt[k] + 1;
            end else if (pop_valid) begin
                m_ptr[k] <= (m_ptr[k] + 7) % 8;
                m_cnt[k] <= (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
            end
        end
    end

    // Compare both DUTs against the model every cycle, away from the active edge.
    always @(negedge CLK) begin
        if ($time > 5) begin
            checkVal("model.r.index", 32'(idx_r), 32'(m_ptr[0]));
            checkVal("model.r.count", 32'(cnt_r), 32'(m_cnt[0]));
            checkVal("model.r.top",   32'(top_r), 32'(m_ent[0][m_ptr[0]]));
            checkVal("model.r.empty", 32'(emp_r), 32'(m_cnt[0] == 0));
            checkVal("model.n.index", 32'(idx_n), 32'(m_ptr[1]));
            checkVal("model.n.count", 32'(cnt_n), 32'(m_cnt[1]));
            checkVal("model.n.top",   32'(top_n), 32'(m_ent[1][m_ptr[1]]));
            checkVal("model.n.empty", 32'(emp_n), 32'(m_cnt[1] == 0));
        end
    end

    initial begin
        #1 RST = 1'b1;
        #2;
        checkOutput("reset", 0, 0, 31'h0, 1'b1);
        @(negedge CLK);
        RST = 1'b0;

        // Basic LIFO
        doPush(31'h100); doPush(31'h200); doPush(31'h300);
        checkOutput("lifo_full", 3, 3, 31'h300, 1'b0);
        doPop(31'h300); doPop(31'h200); doPop(31'h100);
        checkOutput("lifo_empty", 0, 0, 31'h0, 1'b1);

        // Overflow then underflow wrap
        for (int v = 1; v <= 10; v++) doPush(31'(v));
        checkOutput("overflow", 2, 8, 31'd10, 1'b0);
        for (int v = 10; v >= 3; v--) doPop(31'(v));
        checkOutput("drained", 2, 0, 31'd10, 1'b1);
        doPop(31'd10);
        checkOutput("underflow", 1, 0, 31'd9, 1'b1);

        // Replace top with a non-empty and an empty stack
        pulseReset();
        doPush(31'h40);
        applyStimulus(1'b1, 31'h80, 1'b1, 1'b0, '0, '0, '0);
        checkOutput("replace", 1, 1, 31'h80, 1'b0);
        pulseReset();
        applyStimulus(1'b1, 31'h80, 1'b1, 1'b0, '0, '0, '0);
        checkOutput("replace_empty", 0, 1, 31'h80, 1'b0);

        // Restore with and without top repair
        pulseReset();
        doPush(31'h11); doPush(31'h22);
        checkOutput("snapshot", 2, 2, 31'h22, 1'b0);
        doPop(31'h22);
        doPush(31'h99); doPush(31'h33); doPush(31'h44);
        doPop(31'h44);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 3'd2, 4'd2, 31'h22);
        checkOutput("restore", 2, 2, 31'h22, 1'b0);
        checkVal("restore_norepair.top", 32'(top_n), 32'h99);

        // Restore outranks a simultaneous push and pop
        applyStimulus(1'b1, 31'h77, 1'b1, 1'b1, 3'd4, 4'd3, 31'h5A);
        checkOutput("priority", 4, 3, 31'h5A, 1'b0);
        checkVal("priority_norepair.top", 32'(top_n), 32'h44);
        doPop(31'h5A); doPop(31'h33); doPop(31'h22); doPop(31'h11);

        // Restore to a full stack, then saturate the count on push
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 3'd7, 4'd8, 31'h3F);
        checkOutput("restore_full", 7, 8, 31'h3F, 1'b0);
        doPush(31'h66);
        checkOutput("full_push", 0, 8, 31'h66, 1'b0);

        // Asynchronous reset between edges with five entries live
        pulseReset();
        for (int v = 1; v <= 5; v++) doPush(31'(v * 3));
        checkOutput("five", 5, 5, 31'd15, 1'b0);
        #2 RST = 1'b1;
        #1;
        checkOutput("async_reset", 0, 0, 31'h0, 1'b1);
        @(negedge CLK);
        RST = 1'b0;
        doPush(31'h7);
        checkOutput("post_reset_push", 1, 1, 31'h7, 1'b0);

        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
